// File: rtl/ex_pipe_reg_if.sv
// EX/MEM stage handshake and payload bundle.
// The upstream ALU side and the downstream MEM side share one interface instance.
interface ex_pipe_reg_if #(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MEM_OP_W   = 2,
    parameter int unsigned CTRL_OP_W  = 2,
    parameter int unsigned EXP_W      = 3,
    parameter int unsigned NUM_EXC    = 2
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     in_pc;
    logic                  in_br_flag;
    logic [MEM_OP_W-1:0]   in_mem_op;
    logic [DATA_W-1:0]     in_mem_wr_data;
    logic [CTRL_OP_W-1:0]  in_ctrl_op;
    logic [REG_ADDR_W-1:0] in_dst_addr;
    logic                  in_gpr_we_;
    logic [EXP_W-1:0]      in_exp_code;
    logic [DATA_W-1:0]     in_result;
    logic [NUM_EXC-1:0]    in_exc_req;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_pc;
    logic                  out_br_flag;
    logic [MEM_OP_W-1:0]   out_mem_op;
    logic [DATA_W-1:0]     out_mem_wr_data;
    logic [CTRL_OP_W-1:0]  out_ctrl_op;
    logic [REG_ADDR_W-1:0] out_dst_addr;
    logic                  out_gpr_we_;
    logic [EXP_W-1:0]      out_exp_code;
    logic [DATA_W-1:0]     out_result;

    modport master (
        output flush, in_valid, in_pc, in_br_flag, in_mem_op, in_mem_wr_data,
               in_ctrl_op, in_dst_addr, in_gpr_we_, in_exp_code, in_result,
               in_exc_req, out_ready,
        input  in_ready, out_valid, out_pc, out_br_flag, out_mem_op,
               out_mem_wr_data, out_ctrl_op, out_dst_addr, out_gpr_we_,
               out_exp_code, out_result
    );

    modport slave (
        input  flush, in_valid, in_pc, in_br_flag, in_mem_op, in_mem_wr_data,
               in_ctrl_op, in_dst_addr, in_gpr_we_, in_exp_code, in_result,
               in_exc_req, out_ready,
        output in_ready, out_valid, out_pc, out_br_flag, out_mem_op,
               out_mem_wr_data, out_ctrl_op, out_dst_addr, out_gpr_we_,
               out_exp_code, out_result
    );
endinterface

// File: rtl/ex_pipe_reg.sv
// EX/MEM pipeline register: two-entry skid buffer with registered in_ready
// and prioritised local exception injection applied at capture time.
module ex_pipe_reg #(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MEM_OP_W   = 2,
    parameter int unsigned CTRL_OP_W  = 2,
    parameter int unsigned EXP_W      = 3,
    parameter int unsigned NUM_EXC    = 2,
    parameter logic [NUM_EXC*EXP_W-1:0] EXC_CODES = {3'd3, 3'd1}
) (
    input  logic             clk,
    input  logic             reset,
    ex_pipe_reg_if.slave     bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]     pc;
        logic                  br_flag;
        logic [MEM_OP_W-1:0]   mem_op;
        logic [DATA_W-1:0]     mem_wr_data;
        logic [CTRL_OP_W-1:0]  ctrl_op;
        logic [REG_ADDR_W-1:0] dst_addr;
        logic                  gpr_we_;
        logic [EXP_W-1:0]      exp_code;
        logic [DATA_W-1:0]     result;
    } entry_t;

    state_t       state_q, state_d;
    entry_t       main_q, skid_q, idle, cap;
    logic         out_valid_q, in_ready_q;
    logic         accept, drain;
    logic         load_main, load_skid, skid_to_main;
    logic [EXP_W-1:0] exc_code;

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_q & bus.out_ready;

    // Empty-slot payload: everything zero, write enable inactive.
    always_comb begin
        idle         = '0;
        idle.gpr_we_ = 1'b1;
    end

    // Lowest-index request wins: scan high to low so the last hit sticks.
    always_comb begin
        exc_code = '0;
        for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
            if (bus.in_exc_req[i]) exc_code = EXC_CODES[i*int'(EXP_W) +: EXP_W];
        end
    end

    always_comb begin
        cap.pc          = bus.in_pc;
        cap.br_flag     = bus.in_br_flag;
        cap.mem_op      = bus.in_mem_op;
        cap.mem_wr_data = bus.in_mem_wr_data;
        cap.ctrl_op     = bus.in_ctrl_op;
        cap.dst_addr    = bus.in_dst_addr;
        cap.gpr_we_     = bus.in_gpr_we_;
        cap.exp_code    = bus.in_exp_code;
        cap.result      = bus.in_result;
        if (|bus.in_exc_req) begin
            cap.mem_op      = '0;
            cap.mem_wr_data = '0;
            cap.ctrl_op     = '0;
            cap.dst_addr    = '0;
            cap.gpr_we_     = 1'b1;
            cap.exp_code    = exc_code;
            cap.result      = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Occupancy next-state and slot load controls.
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (!accept && drain) begin
                        state_d   = EMPTY;
                    end else if (accept && drain) begin
                        load_main = 1'b1;
                    end
                end
                TWO: if (drain) begin
                    state_d      = ONE;
                    skid_to_main = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q      <= idle;
            skid_q      <= idle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != TWO);
            if (bus.flush) begin
                main_q <= idle;
                skid_q <= idle;
            end else begin
                if (load_main)         main_q <= cap;
                else if (skid_to_main) main_q <= skid_q;
                if (load_skid)         skid_q <= cap;
            end
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_pc          = main_q.pc;
    assign bus.out_br_flag     = main_q.br_flag;
    assign bus.out_mem_op      = main_q.mem_op;
    assign bus.out_mem_wr_data = main_q.mem_wr_data;
    assign bus.out_ctrl_op     = main_q.ctrl_op;
    assign bus.out_dst_addr    = main_q.dst_addr;
    assign bus.out_gpr_we_     = main_q.gpr_we_;
    assign bus.out_exp_code    = main_q.exp_code;
    assign bus.out_result      = main_q.result;
endmodule

// File: tb/tb_ex_pipe_reg.sv
// Bench for ex_pipe_reg: directed scenarios plus random traffic, all checked
// against a two-deep FIFO reference model with capture-time exception rules.
module tb_ex_pipe_reg;
    localparam int unsigned ADDR_W = 30, DATA_W = 32, REG_ADDR_W = 5;
    localparam int unsigned MEM_OP_W = 2, CTRL_OP_W = 2, EXP_W = 3, NUM_EXC = 2;
    localparam logic [NUM_EXC*EXP_W-1:0] EXC_CODES = {3'd3, 3'd1};

    typedef struct {
        logic [ADDR_W-1:0]     pc;
        logic                  br;
        logic [MEM_OP_W-1:0]   mem_op;
        logic [DATA_W-1:0]     wdata;
        logic [CTRL_OP_W-1:0]  ctrl_op;
        logic [REG_ADDR_W-1:0] dst;
        logic                  gwe_;
        logic [EXP_W-1:0]      exp;
        logic [DATA_W-1:0]     result;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    ent_t q[$];
    logic idle = 1'b1;
    logic [EXP_W-1:0] code_tab [NUM_EXC] = '{3'd1, 3'd3};

    always #5 clk = ~clk;

    ex_pipe_reg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
                     .MEM_OP_W(MEM_OP_W), .CTRL_OP_W(CTRL_OP_W), .EXP_W(EXP_W),
                     .NUM_EXC(NUM_EXC)) bus ();

    ex_pipe_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
                  .MEM_OP_W(MEM_OP_W), .CTRL_OP_W(CTRL_OP_W), .EXP_W(EXP_W),
                  .NUM_EXC(NUM_EXC), .EXC_CODES(EXC_CODES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [127:0] pack(input ent_t e);
        return 128'({e.pc, e.br, e.mem_op, e.wdata, e.ctrl_op, e.dst, e.gwe_, e.exp, e.result});
    endfunction

    function automatic logic [127:0] observed();
        return 128'({bus.out_pc, bus.out_br_flag, bus.out_mem_op, bus.out_mem_wr_data,
                     bus.out_ctrl_op, bus.out_dst_addr, bus.out_gpr_we_,
                     bus.out_exp_code, bus.out_result});
    endfunction

    function automatic ent_t idle_ent();
        ent_t e = '{default: '0};
        e.gwe_ = 1'b1;
        return e;
    endfunction

    // What the stage should hold for the inputs currently presented.
    function automatic ent_t model_cap();
        ent_t e;
        e.pc = bus.in_pc;          e.br = bus.in_br_flag;
        e.mem_op = bus.in_mem_op;  e.wdata = bus.in_mem_wr_data;
        e.ctrl_op = bus.in_ctrl_op; e.dst = bus.in_dst_addr;
        e.gwe_ = bus.in_gpr_we_;   e.exp = bus.in_exp_code;
        e.result = bus.in_result;
        for (int i = 0; i < int'(NUM_EXC); i++) begin
            if (bus.in_exc_req[i]) begin
                e.mem_op = '0; e.wdata = '0; e.ctrl_op = '0; e.dst = '0;
                e.gwe_ = 1'b1; e.result = '0; e.exp = code_tab[i];
                return e;
            end
        end
        return e;
    endfunction

    task automatic model_step();
        logic acc, drn;
        acc = bus.in_valid && (q.size() < 2);
        drn = (q.size() != 0) && bus.out_ready;
        if (bus.flush) begin
            q.delete();
            idle = 1'b1;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(model_cap());
                idle = 1'b0;
            end
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ":valid"}, 128'(bus.out_valid), 128'(q.size() != 0));
        chk({tag, ":ready"}, 128'(bus.in_ready), 128'(q.size() < 2));
        if (q.size() != 0)  chk({tag, ":head"}, observed(), pack(q[0]));
        else if (idle)      chk({tag, ":idle"}, observed(), pack(idle_ent()));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1 check_out(tag);
    endtask

    task automatic set_in(input logic v, input logic [ADDR_W-1:0] pc,
                          input logic [NUM_EXC-1:0] exc, input logic [EXP_W-1:0] exp,
                          input logic [MEM_OP_W-1:0] mop, input logic gwe_);
        bus.in_valid = v;          bus.in_pc = pc;
        bus.in_exc_req = exc;      bus.in_exp_code = exp;
        bus.in_mem_op = mop;       bus.in_gpr_we_ = gwe_;
        bus.in_br_flag = 1'($urandom);
        bus.in_mem_wr_data = $urandom;
        bus.in_ctrl_op = CTRL_OP_W'($urandom);
        bus.in_dst_addr = REG_ADDR_W'($urandom);
        bus.in_result = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, '0, '0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_payload", observed(), pack(idle_ent()));
        #3 reset = 1'b0;

        // Back-to-back stream with the sink always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, ADDR_W'(32'h10 + i), '0, '0, 2'd2, 1'b0);
            tick("stream");
            chk("stream_pc", 128'(bus.out_pc), 128'(32'h10 + i));
            chk("stream_rdy", 128'(bus.in_ready), 128'(1));
        end
        bus.in_valid = 1'b0;
        tick("stream_end");

        // Back-pressure fills both slots, then drains in order.
        bus.out_ready = 1'b0;
        set_in(1'b1, 30'h20, '0, '0, 2'd1, 1'b0); tick("bp0");
        set_in(1'b1, 30'h21, '0, '0, 2'd1, 1'b0); tick("bp1");
        chk("bp_full_ready", 128'(bus.in_ready), 128'(0));
        set_in(1'b1, 30'h22, '0, '0, 2'd1, 1'b0); tick("bp2");
        chk("bp_hold_pc", 128'(bus.out_pc), 128'(32'h20));
        bus.out_ready = 1'b1;
        tick("bp_rel0");
        chk("bp_rel0_pc", 128'(bus.out_pc), 128'(32'h21));
        tick("bp_rel1");
        chk("bp_rel1_pc", 128'(bus.out_pc), 128'(32'h22));
        bus.in_valid = 1'b0;
        tick("bp_end");

        // Exception priority and pass-through.
        set_in(1'b1, 30'h30, 2'b11, 3'd5, 2'd1, 1'b0); tick("exc11");
        chk("exc11_code", 128'(bus.out_exp_code), 128'(1));
        chk("exc11_mop", 128'(bus.out_mem_op), 128'(0));
        chk("exc11_we", 128'(bus.out_gpr_we_), 128'(1));
        chk("exc11_res", 128'(bus.out_result), 128'(0));
        chk("exc11_pc", 128'(bus.out_pc), 128'(32'h30));
        set_in(1'b1, 30'h31, 2'b10, 3'd5, 2'd1, 1'b0); tick("exc10");
        chk("exc10_code", 128'(bus.out_exp_code), 128'(3));
        set_in(1'b1, 30'h32, 2'b00, 3'd5, 2'd1, 1'b0); tick("exc00");
        chk("exc00_code", 128'(bus.out_exp_code), 128'(5));
        chk("exc00_we", 128'(bus.out_gpr_we_), 128'(0));
        bus.in_valid = 1'b0;
        tick("exc_end");

        // Flush while full, with an incoming entry in the same cycle.
        bus.out_ready = 1'b0;
        set_in(1'b1, 30'h40, '0, '0, 2'd3, 1'b0); tick("fl0");
        set_in(1'b1, 30'h41, '0, '0, 2'd3, 1'b0); tick("fl1");
        set_in(1'b1, 30'h42, '0, '0, 2'd3, 1'b0);
        bus.flush = 1'b1;
        tick("flush");
        chk("flush_valid", 128'(bus.out_valid), 128'(0));
        chk("flush_ready", 128'(bus.in_ready), 128'(1));
        chk("flush_we", 128'(bus.out_gpr_we_), 128'(1));
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick("post_flush");

        // Asynchronous reset between edges while full.
        bus.out_ready = 1'b0;
        set_in(1'b1, 30'h50, '0, '0, 2'd1, 1'b0); tick("ar0");
        set_in(1'b1, 30'h51, '0, '0, 2'd1, 1'b0); tick("ar1");
        bus.in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 128'(bus.out_valid), 128'(0));
        chk("arst_ready", 128'(bus.in_ready), 128'(1));
        chk("arst_payload", observed(), pack(idle_ent()));
        q.delete();
        idle = 1'b1;
        #2 reset = 1'b0;
        tick("post_arst");

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            set_in(1'($urandom_range(0, 9) < 7), ADDR_W'($urandom),
                   ($urandom_range(0, 3) == 0) ? NUM_EXC'($urandom) : '0,
                   EXP_W'($urandom), MEM_OP_W'($urandom), 1'($urandom));
            bus.out_ready = 1'($urandom_range(0, 9) < 6);
            bus.flush = ($urandom_range(0, 39) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
